// File: rtl/msi_snoop_ctrl.sv
// MSI snooping cache controller: direct-mapped line array, CPU request FSM,
// bus transaction generation and snoop response for one processor.
module msi_snoop_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [1:0]        bus_msg,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wb,
    output logic [DATA_W-1:0] bus_wb_data,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_msg,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic [1:0]        current_state,
    output logic [ADDR_W-1:0] current_address,
    output logic [DATA_W-1:0] current_data
);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int LINES = 2 ** IDX_W;

    typedef enum logic [1:0] {LS_I = 2'b00, LS_S = 2'b01, LS_M = 2'b10} line_t;
    typedef enum logic [1:0] {MSG_NONE = 2'b00, MSG_RM = 2'b01, MSG_WM = 2'b10, MSG_INV = 2'b11} msg_t;
    typedef enum logic [2:0] {IDLE, WB, ARB, FILL, DONE} fsm_t;

    line_t             lstate [LINES];
    logic [TAG_W-1:0]  ltag   [LINES];
    logic [DATA_W-1:0] ldata  [LINES];

    fsm_t              fsm;
    msg_t              pend;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic [IDX_W-1:0]  c_idx, r_idx, s_idx;
    logic [TAG_W-1:0]  c_tag, r_tag, s_tag;
    logic              c_hit, s_hit, s_flush, s_inv, s_chg, s_kills_req;
    line_t             s_next;
    msg_t              eff_msg;

    assign c_idx = cpu_addr[IDX_W-1:0];
    assign c_tag = cpu_addr[ADDR_W-1:IDX_W];
    assign r_idx = req_addr[IDX_W-1:0];
    assign r_tag = req_addr[ADDR_W-1:IDX_W];
    assign s_idx = snoop_addr[IDX_W-1:0];
    assign s_tag = snoop_addr[ADDR_W-1:IDX_W];

    assign c_hit   = (lstate[c_idx] != LS_I) && (ltag[c_idx] == c_tag);
    assign s_hit   = snoop_valid && (snoop_msg != MSG_NONE) &&
                     (lstate[s_idx] != LS_I) && (ltag[s_idx] == s_tag);
    assign s_flush = s_hit && (lstate[s_idx] == LS_M) &&
                     (snoop_msg == MSG_RM || snoop_msg == MSG_WM);
    assign s_inv   = s_hit && (lstate[s_idx] == LS_S) &&
                     (snoop_msg == MSG_WM || snoop_msg == MSG_INV);
    assign s_chg   = s_flush || s_inv;
    // The S copy an INVALIDATE is waiting to upgrade has just been taken away.
    assign s_kills_req = s_inv && (snoop_addr == req_addr);

    always_comb begin
        s_next  = (s_flush && snoop_msg == MSG_RM) ? LS_S : LS_I;
        eff_msg = (pend == MSG_INV && s_kills_req) ? MSG_WM : pend;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lstate          <= '{default: LS_I};
            ltag            <= '{default: '0};
            ldata           <= '{default: '0};
            fsm             <= IDLE;
            pend            <= MSG_NONE;
            req_write       <= 1'b0;
            req_addr        <= '0;
            req_wdata       <= '0;
            cpu_ready       <= 1'b0;
            cpu_rdata       <= '0;
            bus_req         <= 1'b0;
            bus_msg         <= MSG_NONE;
            bus_addr        <= '0;
            bus_wb          <= 1'b0;
            bus_wb_data     <= '0;
            current_state   <= LS_I;
            current_address <= '0;
            current_data    <= '0;
        end else begin
            cpu_ready   <= 1'b0;
            bus_msg     <= MSG_NONE;
            bus_addr    <= '0;
            bus_wb      <= 1'b0;
            bus_wb_data <= '0;

            // Snoop side first; CPU-side assignments below override current_*.
            if (s_flush) begin
                bus_wb      <= 1'b1;
                bus_addr    <= snoop_addr;
                bus_wb_data <= ldata[s_idx];
            end
            if (s_chg) begin
                lstate[s_idx]   <= s_next;
                current_state   <= s_next;
                current_address <= snoop_addr;
                current_data    <= ldata[s_idx];
            end

            case (fsm)
                IDLE: begin
                    if (cpu_req && !cpu_ready && !(s_chg && s_idx == c_idx)) begin
                        req_write <= cpu_write;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        if (c_hit && !cpu_write) begin
                            cpu_ready <= 1'b1;
                            cpu_rdata <= ldata[c_idx];
                        end else if (c_hit && lstate[c_idx] == LS_M) begin
                            ldata[c_idx]    <= cpu_wdata;
                            cpu_ready       <= 1'b1;
                            cpu_rdata       <= cpu_wdata;
                            current_state   <= LS_M;
                            current_address <= cpu_addr;
                            current_data    <= cpu_wdata;
                        end else if (c_hit) begin
                            pend    <= MSG_INV;
                            bus_req <= 1'b1;
                            fsm     <= ARB;
                        end else begin
                            pend <= cpu_write ? MSG_WM : MSG_RM;
                            if (lstate[c_idx] == LS_M) begin
                                fsm <= WB;
                            end else begin
                                bus_req <= 1'b1;
                                fsm     <= ARB;
                            end
                        end
                    end
                end
                WB: begin
                    // A snoop flush owns bus_wb this cycle; retry, and skip the
                    // write-back entirely if the snoop already took the victim out of M.
                    if (!s_flush) begin
                        if (lstate[r_idx] == LS_M) begin
                            bus_wb          <= 1'b1;
                            bus_addr        <= {ltag[r_idx], r_idx};
                            bus_wb_data     <= ldata[r_idx];
                            lstate[r_idx]   <= LS_I;
                            current_state   <= LS_I;
                            current_address <= {ltag[r_idx], r_idx};
                            current_data    <= ldata[r_idx];
                        end
                        bus_req <= 1'b1;
                        fsm     <= ARB;
                    end
                end
                ARB: begin
                    // bus_addr is shared with snoop flushes, so a grant is taken
                    // only in a cycle without one; the arbiter holds grant while bus_req.
                    if (bus_grant && !s_flush) begin
                        bus_req  <= 1'b0;
                        bus_msg  <= eff_msg;
                        bus_addr <= req_addr;
                        pend     <= eff_msg;
                        if (eff_msg == MSG_INV) begin
                            lstate[r_idx]   <= LS_M;
                            ldata[r_idx]    <= req_wdata;
                            cpu_ready       <= 1'b1;
                            cpu_rdata       <= req_wdata;
                            current_state   <= LS_M;
                            current_address <= req_addr;
                            current_data    <= req_wdata;
                            fsm             <= DONE;
                        end else begin
                            fsm <= FILL;
                        end
                    end else begin
                        pend <= eff_msg;
                    end
                end
                FILL: begin
                    // Any snoop match here concerns the departing tag; the fill replaces it.
                    if (mem_valid) begin
                        lstate[r_idx]   <= req_write ? LS_M : LS_S;
                        ltag[r_idx]     <= r_tag;
                        ldata[r_idx]    <= req_write ? req_wdata : mem_data;
                        cpu_ready       <= 1'b1;
                        cpu_rdata       <= req_write ? req_wdata : mem_data;
                        current_state   <= req_write ? LS_M : LS_S;
                        current_address <= req_addr;
                        current_data    <= req_write ? req_wdata : mem_data;
                        fsm             <= DONE;
                    end
                end
                DONE: begin
                    fsm <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/msi_snoop_ctrl.md
Name: msi_snoop_ctrl

Overview:
- Per-processor MSI snooping cache controller; sits directly upstream of the processor-side cache display stage.
- Accepts CPU read/write requests and looks up a small direct-mapped line array.
- Issues bus transactions (read miss, write miss, invalidate, write-back) and reacts to snooped bus traffic from the other processor.
- Produces current_state/current_address/current_data for the line last touched; these drive the cache display stage.

Parameters:
ADDR_W, 3, CPU/bus address width
DATA_W, 4, data word width (one word per line)
IDX_W, 2, index bits; 2**IDX_W lines; tag = address[ADDR_W-1:IDX_W]

Ports:
clock  in  1  single system clock, rising edge
reset_n  in  1  synchronous reset, active-low
cpu_req  in  1  CPU request valid; held until cpu_ready
cpu_write  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  request address
cpu_wdata  in  DATA_W  write data
cpu_ready  out  1  one-cycle pulse when the request completes
cpu_rdata  out  DATA_W  read data, valid with cpu_ready
bus_req  out  1  request bus ownership
bus_grant  in  1  bus granted; sampled while bus_req=1
bus_msg  out  2  00 none, 01 READ_MISS, 10 WRITE_MISS, 11 INVALIDATE
bus_addr  out  ADDR_W  address of bus_msg or write-back
bus_wb  out  1  write-back valid (victim or snoop flush)
bus_wb_data  out  DATA_W  write-back data
mem_valid  in  1  fill data valid
mem_data  in  DATA_W  fill data
snoop_valid  in  1  other processor's bus message valid
snoop_msg  in  2  same encoding as bus_msg
snoop_addr  in  ADDR_W  snooped address
current_state  out  2  MSI state of last-touched line
current_address  out  ADDR_W  its address
current_data  out  DATA_W  its data

Behaviour:
- Line state encoding: I=00, S=01, M=10; 11 is never stored.
- Each line holds state, tag and data.
- Reset (reset_n=0 at a clock edge):
  - all lines go to I, tag 0, data 0;
  - FSM goes to IDLE;
  - every output goes to 0.
  - Reset mid-transaction abandons it; no write-back is issued.
- FSM states: IDLE, WB, ARB, FILL, DONE.
- IDLE, cpu_req=1: lookup at the edge. Hit = state≠I and tag match.
  - Read hit, or write hit on M: the line is updated at that edge (a write stores data). cpu_ready=1 and cpu_rdata are driven the next cycle (1-cycle latency). Stay in IDLE.
  - Write hit on S: go to ARB with INVALIDATE pending.
  - Miss with victim in M: go to WB.
  - Miss otherwise: go to ARB with READ_MISS or WRITE_MISS.
- WB: bus_wb=1 for exactly one cycle, carrying the victim's bus_addr and data. Victim state becomes I. Then go to ARB.
- ARB: bus_req=1 until bus_grant=1.
  - In the grant cycle, bus_msg/bus_addr are driven for exactly one cycle.
  - INVALIDATE: the line becomes M and the write data is stored; go to DONE.
  - Miss: go to FILL.
- FILL: wait for mem_valid; no timeout.
  - Read: line = S with mem_data.
  - Write: line = M with cpu_wdata.
  - Tag is updated. Go to DONE.
- DONE: cpu_ready=1 for one cycle (read data = fill data). Return to IDLE. cpu_req must not be re-sampled in the same cycle.
- Snoop handling runs in every state and takes priority over CPU-side line updates on the same index in the same edge.
  - Matching line in M, READ_MISS: bus_wb=1 next cycle with line data; line becomes S.
  - Matching line in M, WRITE_MISS: bus_wb=1 next cycle with line data; line becomes I.
  - Matching line in S, WRITE_MISS or INVALIDATE: line becomes I.
  - Matching line in S, READ_MISS: no change.
  - No match, or line in I: no action.
- Snoop during ARB with INVALIDATE pending on the same line: if the line is invalidated, the pending message converts to WRITE_MISS and the FSM proceeds through FILL.
- Snoop flush collides with a WB-state write-back in the same cycle: the snoop flush goes first; WB is delayed one cycle.
- current_*:
  - Updated whenever a line changes due to CPU activity or a snoop.
  - If both update in one cycle, the CPU-side update is reported.
  - Held otherwise.
- Widths: the tag is compared with equality on ADDR_W-IDX_W bits; no arithmetic.

Test Plan:
- Reset then read addr 3'b101: READ_MISS on bus, grant, mem_data=4'hA → cpu_ready with cpu_rdata=4'hA; current_state=01, current_address=101.
- Write 4'h7 to 3'b101 while in S: INVALIDATE issued, grant → line M, data 7, cpu_ready after DONE; a following read hit returns 7 in 1 cycle with no bus activity.
- Line 3'b101 in M, data 7; snoop READ_MISS 3'b101 → next cycle bus_wb=1, bus_wb_data=7, bus_addr=101; state 01.
- Line 3'b001 in M; CPU reads 3'b101 (same index) → WB of 001 first, then READ_MISS, fill; victim ends I.
- INVALIDATE pending in ARB; snoop WRITE_MISS on the same address before grant → WRITE_MISS issued instead, FILL waits for mem_valid, line ends M with cpu_wdata.
- reset_n=0 during FILL → next cycle all outputs 0, lines I; a later read misses.
